// File: rtl/uart_xcvr_pkg.sv
// uart_xcvr_pkg
//   Shared definitions for the UART transceiver: FSM state encoding used by
//   both the TX and RX machines, default timing values and a counter-width
//   helper.
package uart_xcvr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // 50 MHz / (115200 * 16) ~ 27
  localparam int DEF_CLK_DIV    = 27;
  localparam int DEF_OVERSAMPLE = 16;

  // Bits needed for a counter running 0..n-1 (never narrower than 1).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
//   Free-running divider producing the oversample tick shared by TX and RX.
//   Counter runs 0..CLK_DIV-1; o_tick is high for the single cycle in which
//   the counter wraps.
// Ports
//   clk     in   system clock
//   reset   in   synchronous, active-high reset (counter -> 0)
//   o_tick  out  1-cycle oversample tick
module uart_baud_gen
  import uart_xcvr_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int              CW   = cnt_w(CLK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)              r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + CW'(1);
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr
//   Full-duplex UART transceiver in a single clock domain. One divider
//   (uart_baud_gen) produces an oversample tick; the TX FSM holds each bit
//   for OVERSAMPLE ticks, the RX FSM samples each bit at its middle after
//   detecting a falling edge on the synchronised rx line.
//   Optional feature: define UART_PARITY_EN to add a parity bit
//   (XOR(data) ^ PARITY_ODD) after the data bits in both directions.
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   start_transmission  send request, honoured only while busy==0
//   data_in             TX word, captured on the accepting edge
//   tx / busy           serial output (idle high) / TX frame in progress
//   rx                  asynchronous serial input (idle high)
//   data_out            last received word, held until the next frame
//   data_ready          1-cycle pulse when data_out updates
//   frame_err           pulse with data_ready: a stop bit sampled 0
//   parity_err          pulse with data_ready: parity mismatch (0 without parity)
module uart_xcvr
  import uart_xcvr_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_transmission,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx,
  output logic              busy,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              data_ready,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int              TC_W    = cnt_w(OVERSAMPLE);
  localparam int              BC_W    = cnt_w(DATA_W);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVERSAMPLE - 1);
  localparam logic [TC_W-1:0] TC_HALF = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BC_W-1:0] BC_DATA = BC_W'(DATA_W - 1);
  localparam logic [BC_W-1:0] BC_STOP = BC_W'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
  localparam logic            PAR_SENSE = (PARITY_ODD != 0);
`endif

  if (CLK_DIV < 2 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_W < 5 || DATA_W > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_xcvr: parameter out of range");
  end

  logic w_tick;

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  // ---------------- TX ----------------
  uart_state_e       r_tx_state, w_tx_state;
  logic [DATA_W-1:0] r_tx_shift, w_tx_shift;
  logic [TC_W-1:0]   r_tx_tc, w_tx_tc;
  logic [BC_W-1:0]   r_tx_bc, w_tx_bc;
  logic              r_tx, w_tx;
  logic              r_tx_go, w_tx_go;   // start bit already on the line
`ifdef UART_PARITY_EN
  logic              r_tx_par, w_tx_par;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= ST_IDLE;
      r_tx       <= 1'b1;
      r_tx_go    <= 1'b0;
      r_tx_tc    <= '0;
      r_tx_bc    <= '0;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx       <= w_tx;
      r_tx_go    <= w_tx_go;
      r_tx_tc    <= w_tx_tc;
      r_tx_bc    <= w_tx_bc;
    end
  end

  always_ff @(posedge clk) begin
    r_tx_shift <= w_tx_shift;
`ifdef UART_PARITY_EN
    r_tx_par   <= w_tx_par;
`endif
  end

  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_shift = r_tx_shift;
    w_tx_tc    = r_tx_tc;
    w_tx_bc    = r_tx_bc;
    w_tx       = r_tx;
    w_tx_go    = r_tx_go;
`ifdef UART_PARITY_EN
    w_tx_par   = r_tx_par;
`endif
    // Tick counter is common to every active state; bit-end branches below reset it.
    if (w_tick && r_tx_state != ST_IDLE) w_tx_tc = r_tx_tc + TC_W'(1);
    case (r_tx_state)
      ST_IDLE: begin
        w_tx = 1'b1;
        if (start_transmission) begin
          w_tx_state = ST_START;
          w_tx_shift = data_in;
          w_tx_go    = 1'b0;
          w_tx_tc    = '0;
`ifdef UART_PARITY_EN
          w_tx_par   = (^data_in) ^ PAR_SENSE;
`endif
        end
      end
      ST_START: begin
        if (w_tick && !r_tx_go) begin
          // First tick after acceptance: the start bit begins here.
          w_tx_go = 1'b1;
          w_tx    = 1'b0;
          w_tx_tc = '0;
        end else if (w_tick && r_tx_tc == TC_LAST) begin
          w_tx_state = ST_DATA;
          w_tx       = r_tx_shift[0];
          w_tx_shift = r_tx_shift >> 1;
          w_tx_tc    = '0;
          w_tx_bc    = '0;
        end
      end
      ST_DATA: begin
        if (w_tick && r_tx_tc == TC_LAST) begin
          w_tx_tc = '0;
          if (r_tx_bc == BC_DATA) begin
            w_tx_bc    = '0;
`ifdef UART_PARITY_EN
            w_tx_state = ST_PARITY;
            w_tx       = r_tx_par;
`else
            w_tx_state = ST_STOP;
            w_tx       = 1'b1;
`endif
          end else begin
            w_tx       = r_tx_shift[0];
            w_tx_shift = r_tx_shift >> 1;
            w_tx_bc    = r_tx_bc + BC_W'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (w_tick && r_tx_tc == TC_LAST) begin
          w_tx_state = ST_STOP;
          w_tx       = 1'b1;
          w_tx_tc    = '0;
          w_tx_bc    = '0;
        end
      end
`endif
      ST_STOP: begin
        if (w_tick && r_tx_tc == TC_LAST) begin
          w_tx_tc = '0;
          if (r_tx_bc == BC_STOP) begin
            w_tx_state = ST_IDLE;
            w_tx_go    = 1'b0;
          end else begin
            w_tx_bc = r_tx_bc + BC_W'(1);
          end
        end
      end
      default: begin
        w_tx_state = ST_IDLE;
        w_tx       = 1'b1;
        w_tx_go    = 1'b0;
      end
    endcase
  end

  assign tx   = r_tx;
  assign busy = (r_tx_state != ST_IDLE);

  // ---------------- RX ----------------
  // r_rx_s3 is the previous synchronised value, used for falling-edge detect.
  logic r_rx_s1, r_rx_s2, r_rx_s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  uart_state_e       r_rx_state, w_rx_state;
  logic [DATA_W-1:0] r_rx_shift, w_rx_shift;
  logic [TC_W-1:0]   r_rx_tc, w_rx_tc;
  logic [BC_W-1:0]   r_rx_bc, w_rx_bc;
  logic              r_rx_ferr, w_rx_ferr;   // stop bits seen low so far
  logic [DATA_W-1:0] r_dout, w_dout;
  logic              r_rdy, w_rdy, r_fe, w_fe;
`ifdef UART_PARITY_EN
  logic              r_rx_par, w_rx_par, r_pe, w_pe;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= ST_IDLE;
      r_rx_tc    <= '0;
      r_rx_bc    <= '0;
      r_rx_ferr  <= 1'b0;
      r_dout     <= '0;
      r_rdy      <= 1'b0;
      r_fe       <= 1'b0;
`ifdef UART_PARITY_EN
      r_pe       <= 1'b0;
`endif
    end else begin
      r_rx_state <= w_rx_state;
      r_rx_tc    <= w_rx_tc;
      r_rx_bc    <= w_rx_bc;
      r_rx_ferr  <= w_rx_ferr;
      r_dout     <= w_dout;
      r_rdy      <= w_rdy;
      r_fe       <= w_fe;
`ifdef UART_PARITY_EN
      r_pe       <= w_pe;
`endif
    end
  end

  always_ff @(posedge clk) begin
    r_rx_shift <= w_rx_shift;
`ifdef UART_PARITY_EN
    r_rx_par   <= w_rx_par;
`endif
  end

  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_shift = r_rx_shift;
    w_rx_tc    = r_rx_tc;
    w_rx_bc    = r_rx_bc;
    w_rx_ferr  = r_rx_ferr;
    w_dout     = r_dout;
    w_rdy      = 1'b0;
    w_fe       = 1'b0;
`ifdef UART_PARITY_EN
    w_rx_par   = r_rx_par;
    w_pe       = 1'b0;
`endif
    if (w_tick && r_rx_state != ST_IDLE) w_rx_tc = r_rx_tc + TC_W'(1);
    case (r_rx_state)
      ST_IDLE: begin
        // Edge required: a line stuck low never restarts the receiver.
        if (r_rx_s3 && !r_rx_s2) begin
          w_rx_state = ST_START;
          w_rx_tc    = '0;
        end
      end
      ST_START: begin
        if (w_tick && r_rx_tc == TC_HALF) begin
          w_rx_tc    = '0;
          w_rx_bc    = '0;
          w_rx_state = r_rx_s2 ? ST_IDLE : ST_DATA;   // high at mid-start: glitch
        end
      end
      ST_DATA: begin
        if (w_tick && r_rx_tc == TC_LAST) begin
          w_rx_tc    = '0;
          w_rx_shift = {r_rx_s2, r_rx_shift[DATA_W-1:1]};
          if (r_rx_bc == BC_DATA) begin
            w_rx_bc    = '0;
            w_rx_ferr  = 1'b0;
`ifdef UART_PARITY_EN
            w_rx_state = ST_PARITY;
`else
            w_rx_state = ST_STOP;
`endif
          end else begin
            w_rx_bc = r_rx_bc + BC_W'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (w_tick && r_rx_tc == TC_LAST) begin
          w_rx_tc    = '0;
          w_rx_par   = r_rx_s2;
          w_rx_state = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_tick && r_rx_tc == TC_LAST) begin
          w_rx_tc = '0;
          if (r_rx_bc == BC_STOP) begin
            // Return to IDLE mid-stop-bit so the next start edge is caught early.
            w_rx_state = ST_IDLE;
            w_dout     = r_rx_shift;
            w_rdy      = 1'b1;
            w_fe       = r_rx_ferr | ~r_rx_s2;
`ifdef UART_PARITY_EN
            w_pe       = ((^r_rx_shift) ^ PAR_SENSE) != r_rx_par;
`endif
          end else begin
            w_rx_bc   = r_rx_bc + BC_W'(1);
            w_rx_ferr = r_rx_ferr | ~r_rx_s2;
          end
        end
      end
      default: w_rx_state = ST_IDLE;
    endcase
  end

  assign data_out   = r_dout;
  assign data_ready = r_rdy;
  assign frame_err  = r_fe;
`ifdef UART_PARITY_EN
  assign parity_err = r_pe;
`else
  assign parity_err = 1'b0;
`endif

endmodule
